// File: rtl/bf_datapath_core_pkg.sv
// Shared definitions for the BeeF datapath core: word types and the encodings
// of the control fields driven by control_unit.
package bf_datapath_core_pkg;

    localparam int BYTE_W = 8;
    localparam int PC_W   = 2 * BYTE_W;

    typedef logic [BYTE_W-1:0] BYTE;
    typedef logic [PC_W-1:0]   PROGRAM_COUNTER;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_INC  = 3'd1,
        ALU_DEC  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_ZERO = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_ACC   = 2'd0,
        SRC_STACK = 2'd1,
        SRC_HEAD  = 2'd2,
        SRC_CACHE = 2'd3
    } alu_src_t;

    typedef enum logic [0:0] {
        ACC_FROM_ALU = 1'b0,
        ACC_FROM_MEM = 1'b1
    } acc_src_t;

    typedef enum logic [1:0] {
        LDR_NONE = 2'd0,
        LDR_LO   = 2'd1,
        LDR_HI   = 2'd2,
        LDR_CLR  = 2'd3
    } loader_sel_t;

endpackage

// File: rtl/bf_datapath_core_alu.sv
// Combinational ALU: selects operand X from acc/stack/head/cache and applies
// the requested operation; results wrap modulo 2**DW and no flags are produced.
module bf_alu
    import bf_datapath_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    alu_op,
    input  logic [1:0]    alu_src,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] stack,
    input  logic [DW-1:0] head,
    input  logic [DW-1:0] cache,
    output logic [DW-1:0] result
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] x;

    always_comb begin
        x = acc;
        case (alu_src_t'(alu_src))
            SRC_ACC:   x = acc;
            SRC_STACK: x = stack;
            SRC_HEAD:  x = head;
            SRC_CACHE: x = cache;
            default:   x = acc;
        endcase
    end

    // Opcodes 6 and 7 are unassigned and deliberately yield zero.
    always_comb begin
        result = '0;
        case (alu_op_t'(alu_op))
            ALU_PASS: result = x;
            ALU_INC:  result = x + ONE;
            ALU_DEC:  result = x - ONE;
            ALU_ADD:  result = acc + x;
            ALU_SUB:  result = acc - x;
            ALU_ZERO: result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/bf_datapath_core.sv
// BeeF datapath core: accumulator, ALU, cache byte and the PC loader/saver
// that assembles loop branch targets a byte at a time from data memory.
module bf_datapath_core
    import bf_datapath_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acc_write,
    input  logic          acc_src,
    input  logic [2:0]    alu_op,
    input  logic [1:0]    alu_src,
    input  logic [DW-1:0] stack_out,
    input  logic [DW-1:0] head_out,
    input  logic [DW-1:0] mem_out,
    input  logic          cache_write,
    input  logic [1:0]    loader_select,
    input  logic [PW-1:0] pc,
    output logic [DW-1:0] acc_out,
    output logic          acc_zero,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] cache_out,
    output logic [DW-1:0] save_out,
    output logic [PW-1:0] load_out
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] cache_q;
    logic [PW-1:0] load_q;

    bf_alu #(.DW(DW)) u_alu (
        .alu_op  (alu_op),
        .alu_src (alu_src),
        .acc     (acc_q),
        .stack   (stack_out),
        .head    (head_out),
        .cache   (cache_q),
        .result  (alu_out)
    );

    // acc feeds the ALU only through this register, so read-modify-write of
    // the accumulator in one cycle is loop-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (acc_write) begin
            acc_q <= (acc_src == ACC_FROM_MEM) ? mem_out : alu_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_q <= '0;
        end else if (cache_write) begin
            cache_q <= alu_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q <= '0;
        end else begin
            case (loader_sel_t'(loader_select))
                LDR_LO:  load_q[DW-1:0]  <= mem_out;
                LDR_HI:  load_q[PW-1:DW] <= mem_out;
                LDR_CLR: load_q          <= '0;
                default: load_q          <= load_q;
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign acc_zero  = (acc_q == '0);
    assign cache_out = cache_q;
    assign load_out  = load_q;
    // The saver pairs with the loader: HI selects the upper PC byte.
    assign save_out  = (loader_select == LDR_HI) ? pc[PW-1:DW] : pc[DW-1:0];

endmodule

// File: tb/tb_bf_datapath_core.sv
// Self-checking bench for bf_datapath_core: directed scenarios plus random
// cycles, all checked against an arithmetic reference model of the datapath.
module tb_bf_datapath_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        acc_write;
    logic        acc_src;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src;
    logic [7:0]  stack_out;
    logic [7:0]  head_out;
    logic [7:0]  mem_out;
    logic        cache_write;
    logic [1:0]  loader_select;
    logic [15:0] pc;
    logic [7:0]  acc_out;
    logic        acc_zero;
    logic [7:0]  alu_out;
    logic [7:0]  cache_out;
    logic [7:0]  save_out;
    logic [15:0] load_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_acc;
    logic [7:0]  m_cache;
    logic [15:0] m_load;

    bf_datapath_core #(.DW(8), .PW(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .acc_write     (acc_write),
        .acc_src       (acc_src),
        .alu_op        (alu_op),
        .alu_src       (alu_src),
        .stack_out     (stack_out),
        .head_out      (head_out),
        .mem_out       (mem_out),
        .cache_write   (cache_write),
        .loader_select (loader_select),
        .pc            (pc),
        .acc_out       (acc_out),
        .acc_zero      (acc_zero),
        .alu_out       (alu_out),
        .cache_out     (cache_out),
        .save_out      (save_out),
        .load_out      (load_out)
    );

    always #5 clk = ~clk;

    function automatic int ref_x(input int src);
        case (src)
            0:       return int'(m_acc);
            1:       return int'(stack_out);
            2:       return int'(head_out);
            default: return int'(m_cache);
        endcase
    endfunction

    function automatic logic [7:0] ref_alu(input int op, input int src);
        int x;
        int a;
        int r;
        x = ref_x(src);
        a = int'(m_acc);
        case (op)
            0:       r = x;
            1:       r = (x + 1) % 256;
            2:       r = (x + 255) % 256;
            3:       r = (a + x) % 256;
            4:       r = (a + 256 - x) % 256;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic drive(input logic aw, input logic asrc, input int op, input int src,
                         input logic cw, input int ls, input logic [7:0] mem,
                         input logic [7:0] stk, input logic [7:0] hd, input logic [15:0] pcv);
        acc_write     = aw;
        acc_src       = asrc;
        alu_op        = 3'(op);
        alu_src       = 2'(src);
        cache_write   = cw;
        loader_select = 2'(ls);
        mem_out       = mem;
        stack_out     = stk;
        head_out      = hd;
        pc            = pcv;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0000);
    endtask

    // Clock one edge and advance the model from the inputs currently applied.
    task automatic step();
        logic [7:0]  a;
        logic [7:0]  n_acc;
        logic [7:0]  n_cache;
        logic [15:0] n_load;
        a       = ref_alu(int'(alu_op), int'(alu_src));
        n_acc   = acc_write ? (acc_src ? mem_out : a) : m_acc;
        n_cache = cache_write ? a : m_cache;
        case (loader_select)
            2'd1:    n_load = {m_load[15:8], mem_out};
            2'd2:    n_load = {mem_out, m_load[7:0]};
            2'd3:    n_load = 16'h0000;
            default: n_load = m_load;
        endcase
        @(posedge clk);
        #1;
        m_acc   = n_acc;
        m_cache = n_cache;
        m_load  = n_load;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        m_acc = 8'h00; m_cache = 8'h00; m_load = 16'h0000;
        #2;
        n_cmp++;
        if ({acc_out, acc_zero, cache_out, load_out} !== {8'h00, 1'b1, 8'h00, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_state: got acc=%h z=%b cache=%h load=%h, want 00 1 00 0000",
                     acc_out, acc_zero, cache_out, load_out);
        end
        drive(1'b1, 1'b1, 0, 0, 1'b1, 1, 8'hA5, 8'h00, 8'h00, 16'h0000);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({acc_out, cache_out, load_out} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_holds: got acc=%h cache=%h load=%h, want all zero",
                     acc_out, cache_out, load_out);
        end
        idle();
        @(negedge clk);
        reset = 1'b1;
        step();
        n_cmp++;
        if ({acc_out, acc_zero, load_out} !== {8'h00, 1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_release: got acc=%h z=%b load=%h, want 00 1 0000",
                     acc_out, acc_zero, load_out);
        end
    endtask

    task automatic test_inc_dec_wrap();
        drive(1'b1, 1'b1, 0, 0, 1'b0, 0, 8'hFF, 8'h00, 8'h00, 16'h0000);
        step();
        n_cmp++;
        if (acc_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL load_ff: got acc=%h, want ff", acc_out);
        end
        drive(1'b1, 1'b0, 1, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0000);
        n_cmp++;
        if (alu_out !== 8'h00) begin
            n_bad++;
            $display("FAIL inc_alu_wrap: got alu=%h, want 00", alu_out);
        end
        step();
        n_cmp++;
        if ({acc_out, acc_zero} !== {8'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL inc_wrap: got acc=%h z=%b, want 00 1", acc_out, acc_zero);
        end
        drive(1'b1, 1'b0, 2, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0000);
        step();
        n_cmp++;
        if ({acc_out, acc_zero} !== {8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL dec_wrap: got acc=%h z=%b, want ff 0", acc_out, acc_zero);
        end
    endtask

    task automatic test_sources();
        drive(1'b1, 1'b1, 3, 1, 1'b0, 0, 8'h5A, 8'h11, 8'h22, 16'h0000);
        step();
        n_cmp++;
        if (acc_out !== 8'h5A) begin
            n_bad++;
            $display("FAIL acc_from_mem: got acc=%h, want 5a", acc_out);
        end
        drive(1'b0, 1'b0, 0, 2, 1'b1, 0, 8'h00, 8'h00, 8'h10, 16'h0000);
        step();
        n_cmp++;
        if ({cache_out, acc_out} !== {8'h10, 8'h5A}) begin
            n_bad++;
            $display("FAIL cache_from_head: got cache=%h acc=%h, want 10 5a", cache_out, acc_out);
        end
        drive(1'b0, 1'b0, 1, 3, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0000);
        n_cmp++;
        if (alu_out !== 8'h11) begin
            n_bad++;
            $display("FAIL inc_cache_operand: got alu=%h, want 11", alu_out);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 1'b1, 0, 0, 1'b0, 0, 8'h03, 8'h00, 8'h00, 16'h0000);
        step();
        drive(1'b0, 1'b0, 3, 1, 1'b0, 0, 8'h00, 8'h05, 8'h00, 16'h0000);
        n_cmp++;
        if (alu_out !== 8'h08) begin
            n_bad++;
            $display("FAIL add: got alu=%h, want 08", alu_out);
        end
        drive(1'b0, 1'b0, 4, 1, 1'b0, 0, 8'h00, 8'h05, 8'h00, 16'h0000);
        n_cmp++;
        if (alu_out !== 8'hFE) begin
            n_bad++;
            $display("FAIL sub: got alu=%h, want fe", alu_out);
        end
        for (int op = 5; op < 8; op++) begin
            drive(1'b0, 1'b0, op, 1, 1'b0, 0, 8'h00, 8'h05, 8'h00, 16'h0000);
            n_cmp++;
            if (alu_out !== 8'h00) begin
                n_bad++;
                $display("FAIL zero_op%0d: got alu=%h, want 00", op, alu_out);
            end
        end
    endtask

    task automatic test_pc_load_save();
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1, 8'h34, 8'h00, 8'h00, 16'hABCD);
        n_cmp++;
        if (save_out !== 8'hCD) begin
            n_bad++;
            $display("FAIL save_lo: got save=%h, want cd", save_out);
        end
        step();
        n_cmp++;
        if (load_out !== 16'h0034) begin
            n_bad++;
            $display("FAIL load_lo: got load=%h, want 0034", load_out);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0, 2, 8'h12, 8'h00, 8'h00, 16'hABCD);
        n_cmp++;
        if ({save_out, load_out} !== {8'hAB, 16'h0034}) begin
            n_bad++;
            $display("FAIL save_hi: got save=%h load=%h, want ab 0034", save_out, load_out);
        end
        step();
        n_cmp++;
        if (load_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL load_hi: got load=%h, want 1234", load_out);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 8'hEE, 8'h00, 8'h00, 16'hABCD);
        step();
        n_cmp++;
        if (load_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL load_hold: got load=%h, want 1234", load_out);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0, 3, 8'hEE, 8'h00, 8'h00, 16'hABCD);
        n_cmp++;
        if (save_out !== 8'hCD) begin
            n_bad++;
            $display("FAIL save_clr: got save=%h, want cd", save_out);
        end
        step();
        n_cmp++;
        if (load_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL load_clr: got load=%h, want 0000", load_out);
        end
    endtask

    task automatic test_concurrency();
        drive(1'b1, 1'b1, 0, 0, 1'b0, 0, 8'h20, 8'h00, 8'h00, 16'h0000);
        step();
        drive(1'b1, 1'b0, 3, 1, 1'b1, 1, 8'h77, 8'h07, 8'h00, 16'h0000);
        step();
        n_cmp++;
        if ({acc_out, cache_out, load_out} !== {8'h27, 8'h27, 16'h0077}) begin
            n_bad++;
            $display("FAIL concurrent: got acc=%h cache=%h load=%h, want 27 27 0077",
                     acc_out, cache_out, load_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_alu;
        logic [7:0] exp_save;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
            exp_alu  = ref_alu(int'(alu_op), int'(alu_src));
            exp_save = (loader_select == 2'd2) ? pc[15:8] : pc[7:0];
            n_cmp++;
            if ({alu_out, save_out} !== {exp_alu, exp_save}) begin
                n_bad++;
                $display("FAIL rand_comb[%0d]: got alu=%h save=%h, want %h %h",
                         i, alu_out, save_out, exp_alu, exp_save);
            end
            step();
            n_cmp++;
            if ({acc_out, acc_zero, cache_out, load_out} !==
                {m_acc, (m_acc == 8'h00), m_cache, m_load}) begin
                n_bad++;
                $display("FAIL rand_regs[%0d]: got acc=%h z=%b cache=%h load=%h, want %h %b %h %h",
                         i, acc_out, acc_zero, cache_out, load_out,
                         m_acc, (m_acc == 8'h00), m_cache, m_load);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 1'b1, 0, 0, 1'b1, 2, 8'h9C, 8'h00, 8'h00, 16'h0000);
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({acc_out, acc_zero, cache_out, load_out} !== {8'h00, 1'b1, 8'h00, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_mid: got acc=%h z=%b cache=%h load=%h, want 00 1 00 0000",
                     acc_out, acc_zero, cache_out, load_out);
        end
        m_acc = 8'h00; m_cache = 8'h00; m_load = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        idle();
        step();
        n_cmp++;
        if ({acc_out, cache_out, load_out} !== 32'h0) begin
            n_bad++;
            $display("FAIL after_reset_mid: got acc=%h cache=%h load=%h, want all zero",
                     acc_out, cache_out, load_out);
        end
    endtask

    initial begin
        test_reset();
        test_inc_dec_wrap();
        test_sources();
        test_add_sub();
        test_pc_load_save();
        test_concurrency();
        test_random();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
